// File: rtl/arm_hazard_if.sv
// ID-stage to hazard-scoreboard bundle: decoded instruction fields in,
// freeze / issue / forwarding-select decisions out.
interface arm_hazard_if #(
    parameter int REG_ADDR_W = 4,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 16
);
    logic                  fwd_en;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  has_src1;
    logic                  has_src2;
    logic [REG_ADDR_W-1:0] dst;
    logic                  wb_en;
    logic                  mem_read;
    logic                  flush;
    logic                  mem_stall;
    logic                  stall;
    logic                  issue_fire;
    logic [SEL_W-1:0]      fwd_sel1;
    logic [SEL_W-1:0]      fwd_sel2;
    logic [CNT_W-1:0]      stall_cnt;

    // Handshake: issue_valid offers the ID instruction; it transfers into EXE on
    // the next rising edge exactly when issue_fire=1 in that cycle. The offer
    // may be withdrawn at any time; stall=1 asks ID to hold it and insert a bubble.
    modport master (
        output fwd_en, issue_valid, src1, src2, has_src1, has_src2,
               dst, wb_en, mem_read, flush, mem_stall,
        input  stall, issue_fire, fwd_sel1, fwd_sel2, stall_cnt
    );

    modport slave (
        input  fwd_en, issue_valid, src1, src2, has_src1, has_src2,
               dst, wb_en, mem_read, flush, mem_stall,
        output stall, issue_fire, fwd_sel1, fwd_sel2, stall_cnt
    );
endinterface

// File: rtl/arm_hazard_scoreboard.sv
// Tracks DEPTH in-flight instructions after ID, decides load-use / no-forward
// stalls, and selects EXE forwarding sources from younger-first producer matches.
module arm_hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = $clog2(DEPTH),
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    arm_hazard_if.slave  sb
);

    logic [DEPTH-1:0]      e_valid;
    logic [DEPTH-1:0]      e_wb;
    logic [DEPTH-1:0]      e_mr;
    logic [REG_ADDR_W-1:0] e_dst [DEPTH];
    logic [REG_ADDR_W-1:0] e_src1;
    logic [REG_ADDR_W-1:0] e_src2;
    logic                  e_has1;
    logic                  e_has2;
    logic [CNT_W-1:0]      cnt;

    logic                  haz1;
    logic                  haz2;
    logic                  hazard;
    logic [SEL_W-1:0]      sel1;
    logic [SEL_W-1:0]      sel2;

    // Scanning from oldest to youngest lets the youngest match overwrite the rest.
    always_comb begin
        haz1 = 1'b0;
        haz2 = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (sb.has_src1 && e_valid[k] && e_wb[k] && e_dst[k] == sb.src1)
                haz1 = sb.fwd_en ? (e_mr[k] && (k + 1 < LOAD_READY)) : (k <= DEPTH - 2);
            if (sb.has_src2 && e_valid[k] && e_wb[k] && e_dst[k] == sb.src2)
                haz2 = sb.fwd_en ? (e_mr[k] && (k + 1 < LOAD_READY)) : (k <= DEPTH - 2);
        end
        hazard = haz1 | haz2;
    end

    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (sb.fwd_en && e_valid[0] && e_has1 && e_valid[k] && e_wb[k] && e_dst[k] == e_src1)
                sel1 = SEL_W'(k);
            if (sb.fwd_en && e_valid[0] && e_has2 && e_valid[k] && e_wb[k] && e_dst[k] == e_src2)
                sel2 = SEL_W'(k);
        end
    end

    assign sb.stall      = sb.issue_valid & hazard & ~sb.flush;
    assign sb.issue_fire = sb.issue_valid & ~hazard & ~sb.flush & ~sb.mem_stall;
    assign sb.fwd_sel1   = sel1;
    assign sb.fwd_sel2   = sel2;
    assign sb.stall_cnt  = cnt;

    // A memory wait freezes every tracked stage and the stall counter together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid <= '0;
            e_wb    <= '0;
            e_mr    <= '0;
            for (int k = 0; k < DEPTH; k++) e_dst[k] <= '0;
            e_src1  <= '0;
            e_src2  <= '0;
            e_has1  <= 1'b0;
            e_has2  <= 1'b0;
            cnt     <= '0;
        end else if (!sb.mem_stall) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                e_valid[k] <= e_valid[k-1];
                e_wb[k]    <= e_wb[k-1];
                e_mr[k]    <= e_mr[k-1];
                e_dst[k]   <= e_dst[k-1];
            end
            e_valid[0] <= sb.issue_fire;
            e_wb[0]    <= sb.wb_en;
            e_mr[0]    <= sb.mem_read;
            e_dst[0]   <= sb.dst;
            e_src1     <= sb.src1;
            e_src2     <= sb.src2;
            e_has1     <= sb.has_src1;
            e_has2     <= sb.has_src2;
            if (sb.stall && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// Bench for arm_hazard_scoreboard: directed pipeline scenarios plus random
// traffic, all checked against a queue-based model of the in-flight instructions.
module tb_arm_hazard_scoreboard;

    localparam int RW         = 4;
    localparam int DEPTH      = 3;
    localparam int LOAD_READY = 2;
    localparam int SW         = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    arm_hazard_if #(.REG_ADDR_W(RW), .SEL_W(SW), .CNT_W(16)) bus ();
    arm_hazard_if #(.REG_ADDR_W(RW), .SEL_W(SW), .CNT_W(4))  bus4 ();

    assign bus4.fwd_en      = bus.fwd_en;
    assign bus4.issue_valid = bus.issue_valid;
    assign bus4.src1        = bus.src1;
    assign bus4.src2        = bus.src2;
    assign bus4.has_src1    = bus.has_src1;
    assign bus4.has_src2    = bus.has_src2;
    assign bus4.dst         = bus.dst;
    assign bus4.wb_en       = bus.wb_en;
    assign bus4.mem_read    = bus.mem_read;
    assign bus4.flush       = bus.flush;
    assign bus4.mem_stall   = bus.mem_stall;

    arm_hazard_scoreboard #(.REG_ADDR_W(RW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .SEL_W(SW), .CNT_W(16))
        dut (.clk(clk), .rst(rst), .sb(bus));

    arm_hazard_scoreboard #(.REG_ADDR_W(RW), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .SEL_W(SW), .CNT_W(4))
        dut4 (.clk(clk), .rst(rst), .sb(bus4));

    // ---------------- scoreboard state ----------------
    typedef struct {
        bit v; bit wb; bit mr;
        int dst; int s1; int s2;
        bit h1; bit h2;
    } ins_t;

    ins_t pipe[$];
    int   m_cnt;
    int   m_cnt4;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   last_stall, last_fire;
    int   last_sel1, last_sel2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        ins_t b;
        b = '{default: 0};
        pipe = {};
        for (int i = 0; i < DEPTH; i++) pipe.push_back(b);
        m_cnt  = 0;
        m_cnt4 = 0;
    endfunction

    // Distance from ID to the nearest producer of s, or -1.
    function automatic int youngest(int s, bit h);
        if (!h) return -1;
        for (int k = 0; k < pipe.size(); k++)
            if (pipe[k].v && pipe[k].wb && pipe[k].dst == s) return k;
        return -1;
    endfunction

    function automatic bit src_hazard(int k);
        if (k < 0) return 0;
        if (!bus.fwd_en) return k < DEPTH - 1;
        return pipe[k].mr && (k + 1 < LOAD_READY);
    endfunction

    function automatic int exp_sel(int s, bit h);
        if (!bus.fwd_en || !pipe[0].v || !h) return 0;
        for (int k = 1; k < DEPTH; k++)
            if (pipe[k].v && pipe[k].wb && pipe[k].dst == s) return k;
        return 0;
    endfunction

    // One clock: check combinational outputs mid-cycle, then advance the model.
    task automatic step();
        bit   hz, es, ef;
        ins_t n;
        @(negedge clk);
        hz = src_hazard(youngest(int'(bus.src1), bus.has_src1)) ||
             src_hazard(youngest(int'(bus.src2), bus.has_src2));
        es = bus.issue_valid && hz && !bus.flush;
        ef = bus.issue_valid && !hz && !bus.flush && !bus.mem_stall;
        check("stall", bus.stall, es);
        check("issue_fire", bus.issue_fire, ef);
        check("fwd_sel1", bus.fwd_sel1, exp_sel(pipe[0].s1, pipe[0].h1));
        check("fwd_sel2", bus.fwd_sel2, exp_sel(pipe[0].s2, pipe[0].h2));
        check("stall_cnt", bus.stall_cnt, m_cnt);
        check("stall_cnt4", bus4.stall_cnt, m_cnt4);
        check("stall4", bus4.stall, es);
        last_stall = bus.stall;
        last_fire  = bus.issue_fire;
        last_sel1  = int'(bus.fwd_sel1);
        last_sel2  = int'(bus.fwd_sel2);
        @(posedge clk);
        if (!bus.mem_stall) begin
            if (es) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            n = '{v: ef, wb: bus.wb_en, mr: bus.mem_read, dst: int'(bus.dst),
                  s1: int'(bus.src1), s2: int'(bus.src2), h1: bus.has_src1, h2: bus.has_src2};
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_id(input bit iv, input int s1, input bit h1, input int s2, input bit h2,
                          input int d, input bit wb, input bit mr);
        bus.issue_valid = iv;
        bus.src1        = RW'(s1);
        bus.has_src1    = h1;
        bus.src2        = RW'(s2);
        bus.has_src2    = h2;
        bus.dst         = RW'(d);
        bus.wb_en       = wb;
        bus.mem_read    = mr;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    task automatic issue_until_fire(output int nstall);
        bit fired = 0;
        nstall = 0;
        for (int i = 0; i < 8 && !fired; i++) begin
            step();
            if (last_stall) nstall++;
            if (last_fire) fired = 1;
        end
        if (!fired) check("issue_timeout", 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int c0;
        bus.fwd_en    = 1'b1;
        bus.flush     = 1'b0;
        bus.mem_stall = 1'b0;
        set_id(1, 2, 1, 2, 1, 2, 1, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", bus.stall, 0);
        check("rst_fire", bus.issue_fire, 1);
        check("rst_sel1", bus.fwd_sel1, 0);
        check("rst_sel2", bus.fwd_sel2, 0);
        check("rst_cnt", bus.stall_cnt, 0);
        rst = 1'b0;
        idle(2);

        // ALU dependency with forwarding: no stall, EXE picks stage 1
        set_id(1, 0, 0, 0, 0, 3, 1, 0); issue_until_fire(n);
        set_id(1, 3, 1, 0, 0, 4, 1, 0); issue_until_fire(n);
        check("alu_fwd_stalls", n, 0);
        idle(1);
        check("alu_fwd_sel1", last_sel1, 1);
        idle(3);

        // Same dependency without forwarding: two bubbles
        bus.fwd_en = 1'b0;
        set_id(1, 0, 0, 0, 0, 3, 1, 0); issue_until_fire(n);
        set_id(1, 3, 1, 0, 0, 4, 1, 0); issue_until_fire(n);
        check("nofwd_stalls", n, 2);
        idle(1);
        check("nofwd_sel1", last_sel1, 0);
        idle(3);
        bus.fwd_en = 1'b1;

        // Load-use: one bubble, forwarded from stage 2
        c0 = m_cnt;
        set_id(1, 0, 0, 0, 0, 5, 1, 1); issue_until_fire(n);
        set_id(1, 0, 0, 5, 1, 6, 1, 0); issue_until_fire(n);
        check("lu_stalls", n, 1);
        check("lu_cnt", bus.stall_cnt, c0 + 1);
        idle(1);
        check("lu_sel2", last_sel2, 2);
        idle(3);

        // Youngest producer (the load) decides both stall and select
        set_id(1, 0, 0, 0, 0, 2, 1, 0); issue_until_fire(n);
        set_id(1, 0, 0, 0, 0, 2, 1, 1); issue_until_fire(n);
        set_id(1, 2, 1, 0, 0, 7, 1, 0); issue_until_fire(n);
        check("young_stalls", n, 1);
        idle(1);
        check("young_sel1", last_sel1, 2);
        idle(3);
        set_id(1, 0, 0, 0, 0, 2, 1, 1); issue_until_fire(n);
        set_id(1, 2, 0, 0, 0, 7, 1, 0); issue_until_fire(n);
        check("nosrc_stalls", n, 0);
        idle(3);

        // Flush beats a pending load-use hazard and leaves a bubble
        set_id(1, 0, 0, 0, 0, 5, 1, 1); issue_until_fire(n);
        set_id(1, 0, 0, 5, 1, 6, 1, 0);
        bus.flush = 1'b1;
        step();
        check("flush_stall", last_stall, 0);
        check("flush_fire", last_fire, 0);
        bus.flush = 1'b0;
        idle(1);
        check("flush_bubble_sel2", last_sel2, 0);
        idle(3);

        // Memory wait during a load hazard: stall held, nothing moves or counts
        set_id(1, 0, 0, 0, 0, 5, 1, 1); issue_until_fire(n);
        set_id(1, 0, 0, 5, 1, 6, 1, 0);
        bus.mem_stall = 1'b1;
        c0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ms_stall_held", last_stall, 1);
        end
        check("ms_cnt_frozen", bus.stall_cnt, c0);
        bus.mem_stall = 1'b0;
        issue_until_fire(n);
        check("ms_release_stalls", n, 1);
        idle(3);

        // Saturation of the 4-bit counter through a dependent chain
        bus.fwd_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set_id(1, 1, 1, 0, 0, 1, 1, 0);
            issue_until_fire(n);
        end
        check("sat_cnt4", bus4.stall_cnt, 15);
        idle(3);

        // Reset mid-stream with a live hazard in flight
        set_id(1, 0, 0, 0, 0, 3, 1, 0); issue_until_fire(n);
        set_id(1, 3, 1, 0, 0, 4, 1, 0);
        #2 rst = 1'b1;
        #1;
        check("mrst_stall", bus.stall, 0);
        check("mrst_fire", bus.issue_fire, 1);
        check("mrst_sel1", bus.fwd_sel1, 0);
        check("mrst_cnt", bus.stall_cnt, 0);
        check("mrst_cnt4", bus4.stall_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("mrst_stall_hold", bus.stall, 0);
        rst = 1'b0;
        bus.fwd_en = 1'b1;
        idle(1);

        // Random traffic over a small register set to force many collisions
        for (int i = 0; i < 500; i++) begin
            bus.fwd_en    = ($urandom_range(0, 9) != 0);
            bus.flush     = ($urandom_range(0, 9) == 0);
            bus.mem_stall = ($urandom_range(0, 7) == 0);
            set_id($urandom_range(0, 3) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
